// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the control unit, the access sequencer and the RAM.
// The slave view belongs to the sequencer; the master view drives it.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              MEMread;
    logic              MEMwrite;
    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] mdr_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] mdr_rdata;
    logic              mem_done;
    logic              mem_err;

    modport slave (
        input  MEMread, MEMwrite, mar_addr, mdr_wdata, ram_rdata,
        output ram_addr, ram_wdata, ram_re, ram_we,
        output mdr_rdata, mem_done, mem_err
    );

    modport master (
        output MEMread, MEMwrite, mar_addr, mdr_wdata, ram_rdata,
        input  ram_addr, ram_wdata, ram_re, ram_we,
        input  mdr_rdata, mem_done, mem_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Wait-state RAM access sequencer for the CPU control unit.
// Runs one fixed-length read or write per 4-phase MEMread/MEMwrite request.
module mem_access_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus
);
    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE, ERR
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.MEMread && bus.MEMwrite) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else if (bus.MEMread) begin
                    addr_d  = bus.mar_addr;
                    cnt_d   = CNT_W'(READ_WAIT - 1);
                    re_d    = 1'b1;
                    state_d = RD_WAIT;
                end else if (bus.MEMwrite) begin
                    addr_d  = bus.mar_addr;
                    wdata_d = bus.mdr_wdata;
                    cnt_d   = CNT_W'(WRITE_WAIT - 1);
                    we_d    = 1'b1;
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                    re_d  = 1'b1;
                end else begin
                    rdata_d = bus.ram_rdata;
                    state_d = RD_DONE;
                end
            end
            WR_WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                    we_d  = 1'b1;
                end else begin
                    state_d = WR_DONE;
                end
            end
            // First DONE cycle always pulses; later cycles follow the request
            RD_DONE: begin
                done_d = bus.MEMread || !done_q;
                if (!bus.MEMread) state_d = IDLE;
            end
            WR_DONE: begin
                done_d = bus.MEMwrite || !done_q;
                if (!bus.MEMwrite) state_d = IDLE;
            end
            ERR: begin
                if (!bus.MEMread && !bus.MEMwrite) state_d = IDLE;
                else err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_re    = re_q;
    assign bus.ram_we    = we_q;
    assign bus.mdr_rdata = rdata_q;
    assign bus.mem_done  = done_q;
    assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with RAM models and an mdr_rdata scoreboard.
// Instance a uses READ_WAIT=2/WRITE_WAIT=1, instance b uses WRITE_WAIT=3.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    int   re_rises = 0;
    logic done_prev = 1'b0;
    logic re_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    logic [31:0] rd_a, rd_b;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) a ();
    mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b ();

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_WAIT(2), .WRITE_WAIT(1)) u_a (
        .clock(clk), .reset_n(rst_a), .bus(a.slave)
    );
    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_WAIT(2), .WRITE_WAIT(3)) u_b (
        .clock(clk), .reset_n(rst_b), .bus(b.slave)
    );

    // RAM: data for a read shows up one edge after ram_re is seen, garbage otherwise
    always @(posedge clk) begin
        rd_a <= a.ram_re ? mem_a[a.ram_addr] : 32'hBAD0BAD0;
        rd_b <= b.ram_re ? mem_b[b.ram_addr] : 32'hBAD0BAD0;
        if (a.ram_we) mem_a[a.ram_addr] = a.ram_wdata;
        if (b.ram_we) mem_b[b.ram_addr] = b.ram_wdata;
    end
    assign a.ram_rdata = rd_a;
    assign b.ram_rdata = rd_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!a.mem_done && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, a.mem_done}, 32'd1);
    endtask

    // Scoreboard: every completed access must leave the predicted mdr_rdata
    always @(negedge clk) begin
        if (a.mem_done && !done_prev) begin
            if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
            else chk("sb_mdr_rdata", a.mdr_rdata, exp_q.pop_front());
        end
        if (a.ram_re && !re_prev) re_rises++;
        done_prev = a.mem_done;
        re_prev = a.ram_re;
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[9'h054] = 32'h0000_0097;
        mem_b[9'h020] = 32'h55AA_55AA;
        rst_a = 1'b0;
        rst_b = 1'b0;
        a.MEMread = 0; a.MEMwrite = 0; a.mar_addr = '0; a.mdr_wdata = '0;
        b.MEMread = 0; b.MEMwrite = 0; b.mar_addr = '0; b.mdr_wdata = '0;
        repeat (3) tick();
        chk("rst_addr", {23'd0, a.ram_addr}, 32'd0);
        chk("rst_ctl", {28'd0, a.ram_re, a.ram_we, a.mem_done, a.mem_err}, 32'd0);
        chk("rst_mdr", a.mdr_rdata, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Read 0x054
        a.MEMread = 1; a.mar_addr = 9'h054; exp_q.push_back(32'h97);
        tick();
        chk("rd_e1_re", {31'd0, a.ram_re}, 32'd1);
        chk("rd_e1_addr", {23'd0, a.ram_addr}, 32'h054);
        tick();
        chk("rd_e2_re", {31'd0, a.ram_re}, 32'd1);
        chk("rd_e2_done", {31'd0, a.mem_done}, 32'd0);
        tick();
        chk("rd_e3_re", {31'd0, a.ram_re}, 32'd0);
        chk("rd_e3_done", {31'd0, a.mem_done}, 32'd0);
        tick();
        chk("rd_e4_done", {31'd0, a.mem_done}, 32'd1);
        a.MEMread = 0;
        tick();
        chk("rd_drop_done", {31'd0, a.mem_done}, 32'd0);

        // Write 0x063
        a.MEMwrite = 1; a.mar_addr = 9'h063; a.mdr_wdata = 32'hDEADBEEF;
        exp_q.push_back(32'h97);
        tick();
        chk("wr_e1_we", {31'd0, a.ram_we}, 32'd1);
        chk("wr_e1_addr", {23'd0, a.ram_addr}, 32'h063);
        chk("wr_e1_data", a.ram_wdata, 32'hDEADBEEF);
        tick();
        chk("wr_e2_we", {31'd0, a.ram_we}, 32'd0);
        chk("wr_e2_done", {31'd0, a.mem_done}, 32'd0);
        tick();
        chk("wr_e3_done", {31'd0, a.mem_done}, 32'd1);
        a.MEMwrite = 0;
        tick();
        chk("wr_drop_done", {31'd0, a.mem_done}, 32'd0);
        chk("wr_mem", mem_a[9'h063], 32'hDEADBEEF);

        // Read back 0x063
        a.MEMread = 1; exp_q.push_back(32'hDEADBEEF);
        tick();
        wait_done_a("rb_done_timeout");
        a.MEMread = 0;
        tick();

        // Held read: exactly one RAM read, done stays high
        begin
            int r0;
            r0 = re_rises;
            a.MEMread = 1; a.mar_addr = 9'h054; exp_q.push_back(32'h97);
            tick();
            wait_done_a("hold_done_timeout");
            repeat (10) tick();
            chk("hold_done_high", {31'd0, a.mem_done}, 32'd1);
            chk("hold_one_read", re_rises - r0, 32'd1);
            chk("hold_re_low", {31'd0, a.ram_re}, 32'd0);
            a.MEMread = 0;
            tick();
            chk("hold_drop_done", {31'd0, a.mem_done}, 32'd0);
        end

        // Both requests -> error
        a.MEMread = 1; a.MEMwrite = 1;
        tick();
        chk("err_set", {31'd0, a.mem_err}, 32'd1);
        chk("err_en", {30'd0, a.ram_re, a.ram_we}, 32'd0);
        tick();
        chk("err_hold", {31'd0, a.mem_err}, 32'd1);
        a.MEMread = 0; a.MEMwrite = 0;
        tick();
        chk("err_clear", {31'd0, a.mem_err}, 32'd0);
        tick();
        chk("err_idle_en", {30'd0, a.ram_re, a.ram_we}, 32'd0);

        // One-cycle read request still completes with a single done pulse
        a.MEMread = 1; a.mar_addr = 9'h063; exp_q.push_back(32'hDEADBEEF);
        tick();
        a.MEMread = 0;
        tick();
        tick();
        chk("pulse_pre", {31'd0, a.mem_done}, 32'd0);
        tick();
        chk("pulse_hi", {31'd0, a.mem_done}, 32'd1);
        tick();
        chk("pulse_lo", {31'd0, a.mem_done}, 32'd0);

        // Write raised mid-read waits for IDLE, then is accepted
        a.MEMread = 1; a.mar_addr = 9'h054; exp_q.push_back(32'h97);
        tick();
        a.MEMwrite = 1; a.mar_addr = 9'h0AA; a.mdr_wdata = 32'h1234_5678;
        exp_q.push_back(32'h97);
        tick();
        chk("opp_addr_stable", {23'd0, a.ram_addr}, 32'h054);
        chk("opp_we_e2", {31'd0, a.ram_we}, 32'd0);
        tick();
        tick();
        chk("opp_done", {31'd0, a.mem_done}, 32'd1);
        a.MEMread = 0;
        tick();
        chk("opp_idle_we", {31'd0, a.ram_we}, 32'd0);
        tick();
        chk("opp_accept_we", {31'd0, a.ram_we}, 32'd1);
        chk("opp_accept_addr", {23'd0, a.ram_addr}, 32'h0AA);
        a.MEMwrite = 0;
        tick();
        tick();
        chk("opp_wr_done", {31'd0, a.mem_done}, 32'd1);
        tick();
        chk("opp_mem", mem_a[9'h0AA], 32'h1234_5678);

        // Reset in the middle of a WRITE_WAIT=3 write
        b.MEMwrite = 1; b.mar_addr = 9'h010; b.mdr_wdata = 32'hCAFEF00D;
        tick();
        chk("b_we_e1", {31'd0, b.ram_we}, 32'd1);
        tick();
        chk("b_we_e2", {31'd0, b.ram_we}, 32'd1);
        rst_b = 1'b0;
        tick();
        chk("b_rst_ctl", {28'd0, b.ram_re, b.ram_we, b.mem_done, b.mem_err}, 32'd0);
        chk("b_rst_addr", {23'd0, b.ram_addr}, 32'd0);
        chk("b_rst_wdata", b.ram_wdata, 32'd0);
        chk("b_rst_mdr", b.mdr_rdata, 32'd0);
        rst_b = 1'b1; b.MEMwrite = 0;
        tick();
        b.MEMread = 1; b.mar_addr = 9'h020;
        tick();
        chk("b_rd_re", {31'd0, b.ram_re}, 32'd1);
        begin
            int n = 0;
            while (!b.mem_done && n < 20) begin
                tick();
                n++;
            end
        end
        chk("b_rd_done", {31'd0, b.mem_done}, 32'd1);
        chk("b_rd_data", b.mdr_rdata, 32'h55AA_55AA);
        b.MEMread = 0;
        tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
